// File: rtl/parking_time_stamper.sv
// Entry/exit timestamp generator for the parking lot: free-running time base,
// slot occupancy table with entry stamps, and an exit report with elapsed time.
//
// state | meaning
// IDLE  | waiting; exit_req wins over enter_req
// SCAN  | probing one slot per cycle for the lowest free index
// GRANT | claim slot idx, stamp it with now, pulse enter_ack (ok=1)
// FULL  | no free slot found, pulse enter_ack (ok=0)
// EXIT  | report and release exit_slot, pulse exit_ack
module parking_time_stamper #(
    parameter int TW       = 8,
    parameter int SLOTS    = 4,
    parameter int SW       = 2,
    parameter int TICK_DIV = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enter_req,
    output logic          enter_ack,
    output logic          enter_ok,
    output logic [SW-1:0] enter_slot,
    input  logic          exit_req,
    input  logic [SW-1:0] exit_slot,
    output logic          exit_ack,
    output logic          exit_err,
    output logic [TW-1:0] time_in,
    output logic [TW-1:0] time_out,
    output logic [TW-1:0] time_total,
    output logic [TW-1:0] now,
    output logic [SW:0]   occupied_cnt
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = SW + 1;

    typedef enum logic [2:0] {IDLE, SCAN, GRANT, FULL, EXIT} state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   idx, idx_nx;
    logic [DW-1:0]   div;
    logic [SLOTS-1:0] occupied;
    logic [TW-1:0]   stamp [SLOTS];

    logic            ok_q, err_q;
    logic [SW-1:0]   slot_q;
    logic [TW-1:0]   in_q, out_q, tot_q;

    logic            exit_hit;
    logic [TW-1:0]   in_c, out_c, tot_c;

    // Time base runs independently of the transaction FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
            now <= '0;
        end else if (div == DW'(TICK_DIV - 1)) begin
            div <= '0;
            now <= now + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (exit_req) begin
                    state_nx = EXIT;
                end else if (enter_req) begin
                    state_nx = SCAN;
                    idx_nx   = '0;
                end
            end
            SCAN: begin
                if (!occupied[idx])
                    state_nx = GRANT;
                else if (idx == SW'(SLOTS - 1))
                    state_nx = FULL;
                else
                    idx_nx = idx + 1'b1;
            end
            GRANT, FULL, EXIT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Error exits report all-zero times; 0 - 0 keeps time_total at 0 too.
    assign exit_hit = occupied[exit_slot];
    assign in_c     = exit_hit ? stamp[exit_slot] : '0;
    assign out_c    = exit_hit ? now : '0;
    assign tot_c    = out_c - in_c;

    always_comb begin
        enter_ack  = (state == GRANT) || (state == FULL);
        enter_ok   = ok_q;
        enter_slot = slot_q;
        exit_ack   = (state == EXIT);
        exit_err   = err_q;
        time_in    = in_q;
        time_out   = out_q;
        time_total = tot_q;
        if (state == GRANT) begin
            enter_ok   = 1'b1;
            enter_slot = idx;
        end else if (state == FULL) begin
            enter_ok   = 1'b0;
        end else if (state == EXIT) begin
            exit_err   = !exit_hit;
            time_in    = in_c;
            time_out   = out_c;
            time_total = tot_c;
        end
    end

    // Table writes and held report values commit at the end of the ack cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupied <= '0;
            for (int i = 0; i < SLOTS; i++) stamp[i] <= '0;
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
            slot_q <= '0;
            in_q   <= '0;
            out_q  <= '0;
            tot_q  <= '0;
        end else begin
            case (state)
                GRANT: begin
                    occupied[idx] <= 1'b1;
                    stamp[idx]    <= now;
                    ok_q          <= 1'b1;
                    slot_q        <= idx;
                end
                FULL: ok_q <= 1'b0;
                EXIT: begin
                    if (exit_hit) occupied[exit_slot] <= 1'b0;
                    err_q <= !exit_hit;
                    in_q  <= in_c;
                    out_q <= out_c;
                    tot_q <= tot_c;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        occupied_cnt = '0;
        for (int i = 0; i < SLOTS; i++)
            occupied_cnt = occupied_cnt + CW'(occupied[i]);
    end

endmodule

// File: tb/tb_parking_time_stamper.sv
// Directed bench for parking_time_stamper: time-base table plus handshake
// sequences for entry, exit, wrap, full lot, priority and mid-scan reset.
module tb_parking_time_stamper;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enter_req = 1'b0;
    logic       enter_ack, enter_ok;
    logic [1:0] enter_slot;
    logic       exit_req = 1'b0;
    logic [1:0] exit_slot = 2'd0;
    logic       exit_ack, exit_err;
    logic [7:0] time_in, time_out, time_total, now;
    logic [2:0] occupied_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int ecount;

    parking_time_stamper #(.TW(8), .SLOTS(4), .SW(2), .TICK_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .enter_req(enter_req), .enter_ack(enter_ack), .enter_ok(enter_ok),
        .enter_slot(enter_slot),
        .exit_req(exit_req), .exit_slot(exit_slot), .exit_ack(exit_ack),
        .exit_err(exit_err), .time_in(time_in), .time_out(time_out),
        .time_total(time_total), .now(now), .occupied_cnt(occupied_cnt)
    );

    always #5 clk = ~clk;

    // Edges since reset release; now is expected to equal (ecount/4) mod 256.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ecount <= 0;
        else          ecount <= ecount + 1;
    end

    typedef struct {
        int         edge_no;
        logic [7:0] exp_now;
    } tvec_t;
    tvec_t tv [10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic go_to(input int target);
        while (ecount < target) @(negedge clk);
    endtask

    task automatic do_enter(input string name, input int exp_ok, input int exp_slot,
                            input int exp_lat);
        int lat = 0;
        bit got = 0;
        @(negedge clk);
        enter_req = 1'b1;
        for (int i = 1; i <= 12 && !got; i++) begin
            @(negedge clk);
            if (enter_ack) begin got = 1; lat = i; end
        end
        enter_req = 1'b0;
        check({name, "_ack_seen"}, int'(got), 1);
        if (got) begin
            check({name, "_latency"}, lat, exp_lat);
            check({name, "_ok"}, int'(enter_ok), exp_ok);
            check({name, "_slot"}, int'(enter_slot), exp_slot);
        end
    endtask

    task automatic do_exit(input string name, input int slot, input int exp_err,
                           input bit chk_t, input int e_in, input int e_out, input int e_tot);
        bit got = 0;
        int lat = 0;
        @(negedge clk);
        exit_req  = 1'b1;
        exit_slot = 2'(slot);
        for (int i = 1; i <= 6 && !got; i++) begin
            @(negedge clk);
            if (exit_ack) begin got = 1; lat = i; end
        end
        exit_req = 1'b0;
        check({name, "_ack_seen"}, int'(got), 1);
        if (got) begin
            check({name, "_latency"}, lat, 1);
            check({name, "_err"}, int'(exit_err), exp_err);
            if (chk_t) begin
                check({name, "_time_in"}, int'(time_in), e_in);
                check({name, "_time_out"}, int'(time_out), e_out);
                check({name, "_time_total"}, int'(time_total), e_tot);
            end
        end
    endtask

    initial begin
        tv[0] = '{1, 8'd0};     tv[1] = '{3, 8'd0};
        tv[2] = '{4, 8'd1};     tv[3] = '{8, 8'd2};
        tv[4] = '{41, 8'd10};   tv[5] = '{1019, 8'd254};
        tv[6] = '{1020, 8'd255}; tv[7] = '{1023, 8'd255};
        tv[8] = '{1024, 8'd0};  tv[9] = '{1028, 8'd1};

        repeat (2) @(negedge clk);
        check("rst_now", int'(now), 0);
        check("rst_enter_ack", int'(enter_ack), 0);
        check("rst_exit_ack", int'(exit_ack), 0);
        check("rst_occupied_cnt", int'(occupied_cnt), 0);
        check("rst_time_total", int'(time_total), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            go_to(tv[i].edge_no);
            check($sformatf("now_tbl_%0d", tv[i].edge_no), int'(now), int'(tv[i].exp_now));
        end

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2_now", int'(now), 0);
        reset_n = 1'b1;

        // Basic stay: stamp 10, leave at 25.
        go_to(40);
        do_enter("enter_basic", 1, 0, 2);
        @(negedge clk);
        check("cnt_after_enter", int'(occupied_cnt), 1);
        go_to(100);
        do_exit("exit_basic", 0, 0, 1, 10, 25, 15);
        @(negedge clk);
        check("cnt_after_exit", int'(occupied_cnt), 0);
        check("hold_time_total", int'(time_total), 15);

        // Stay crossing the 255 -> 0 wrap: 250 in, 4 out.
        go_to(1000);
        do_enter("enter_wrap", 1, 0, 2);
        go_to(1040);
        do_exit("exit_wrap", 0, 0, 1, 250, 4, 10);

        // Fill the lot, then a fifth car is refused.
        do_enter("fill0", 1, 0, 2);
        do_enter("fill1", 1, 1, 3);
        do_enter("fill2", 1, 2, 4);
        do_enter("fill3", 1, 3, 5);
        do_enter("full", 0, 3, 5);
        check("cnt_full", int'(occupied_cnt), 4);
        do_exit("free2", 2, 0, 0, 0, 0, 0);
        do_enter("regrant2", 1, 2, 4);
        @(negedge clk);
        check("cnt_regrant", int'(occupied_cnt), 4);

        // Simultaneous requests: exit served first, freed slot 1 then granted.
        begin
            int xc = 0, ec = 0;
            @(negedge clk);
            enter_req = 1'b1;
            exit_req  = 1'b1;
            exit_slot = 2'd1;
            for (int i = 1; i <= 12 && ec == 0; i++) begin
                @(negedge clk);
                if (exit_ack) begin
                    xc = i;
                    check("both_exit_err", int'(exit_err), 0);
                    check("both_no_enter_ack", int'(enter_ack), 0);
                    exit_req = 1'b0;
                end
                if (enter_ack) begin
                    ec = i;
                    check("both_enter_slot", int'(enter_slot), 1);
                    check("both_enter_ok", int'(enter_ok), 1);
                end
            end
            enter_req = 1'b0;
            exit_req  = 1'b0;
            check("both_exit_cycle", xc, 1);
            check("both_enter_cycle", ec, 5);
        end

        do_exit("free3", 3, 0, 0, 0, 0, 0);
        do_exit("empty3", 3, 1, 1, 0, 0, 0);
        @(negedge clk);
        check("cnt_after_err", int'(occupied_cnt), 3);

        // Reset while scanning aborts the entry and clears everything.
        begin
            int seen = 0;
            @(negedge clk);
            enter_req = 1'b1;
            repeat (2) @(negedge clk);
            reset_n   = 1'b0;
            enter_req = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (enter_ack || exit_ack) seen++;
            end
            check("scan_rst_no_ack", seen, 0);
            reset_n = 1'b1;
            @(negedge clk);
            check("scan_rst_cnt", int'(occupied_cnt), 0);
            check("scan_rst_now", int'(now), 0);
        end
        do_enter("after_rst", 1, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
